// File: rtl/gen_scheduler.sv
// Game-state controller and generation pacer for the 7x7 Life datapath.
// Edge-detects the front-panel buttons and issues registered one-cycle commands.
module gen_scheduler #(
  parameter int TICK_DIV = 4,
  parameter int CELLS    = 49,
  parameter int GEN_W    = 16
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             stop,
  input  logic             prgm,
  input  logic             pp,
  input  logic             btn0,
  input  logic             btn1,
  input  logic [CELLS-1:0] grid,
  output logic [1:0]       game_state,
  output logic             step,
  output logic             toggle,
  output logic             clear,
  output logic [5:0]       cursor,
  output logic [GEN_W-1:0] gen_count,
  output logic             stable
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [5:0] CUR_LAST = 6'(CELLS - 1);

  typedef enum logic [1:0] {
    ST_STOP    = 2'b00,
    ST_PROGRAM = 2'b01,
    ST_RUN     = 2'b10,
    ST_PAUSE   = 2'b11
  } state_t;

  state_t           r_state, w_state;
  logic [TW-1:0]    r_tick, w_tick;
  logic [CELLS-1:0] r_snap, w_snap;
  logic             r_first, w_first;
  logic             r_advPend, w_advPend;
  logic             r_step, w_step;
  logic             r_toggle, w_toggle;
  logic             r_clear, w_clear;
  logic [5:0]       r_cursor, w_cursor;
  logic [GEN_W-1:0] r_gen, w_gen;
  logic             r_stable, w_stable;
  logic             r_prevPrgm, r_prevPp, r_prevBtn0, r_prevBtn1;

  logic             w_risePrgm, w_risePp, w_riseBtn0, w_riseBtn1;
  logic [5:0]       w_cursorInc;
  logic [GEN_W-1:0] w_genInc;
  logic             w_halt;

  assign w_risePrgm  = prgm & ~r_prevPrgm;
  assign w_risePp    = pp   & ~r_prevPp;
  assign w_riseBtn0  = btn0 & ~r_prevBtn0;
  assign w_riseBtn1  = btn1 & ~r_prevBtn1;
  assign w_cursorInc = (r_cursor == CUR_LAST) ? 6'd0 : r_cursor + 6'd1;
  assign w_genInc    = (r_gen == {GEN_W{1'b1}}) ? r_gen : r_gen + GEN_W'(1);
  // The first step point of a fresh run has no valid snapshot to compare against.
  assign w_halt      = ~r_first & ((grid == r_snap) | (grid == '0));

  always_comb begin
    w_state   = r_state;
    w_tick    = r_tick;
    w_snap    = r_snap;
    w_first   = r_first;
    w_advPend = 1'b0;
    w_step    = 1'b0;
    w_toggle  = 1'b0;
    w_clear   = 1'b0;
    w_cursor  = r_advPend ? w_cursorInc : r_cursor;
    w_gen     = r_gen;
    w_stable  = r_stable;
    if (stop) begin
      w_state = ST_STOP;
      if (r_state != ST_STOP) begin
        w_clear  = 1'b1;
        w_cursor = 6'd0;
        w_gen    = '0;
        w_tick   = '0;
        w_stable = 1'b0;
      end
    end else begin
      case (r_state)
        ST_STOP: begin
          if (w_risePrgm) begin
            w_state = ST_PROGRAM;
          end else if (w_risePp) begin
            w_state = ST_RUN;
            w_tick  = '0;
            w_first = 1'b1;
          end
        end
        ST_PROGRAM: begin
          if (w_risePp) begin
            w_state = ST_RUN;
            w_tick  = '0;
            w_first = 1'b1;
          end else if (w_riseBtn1) begin
            // A simultaneous advance waits one cycle so the toggle hits the old cell.
            w_toggle  = 1'b1;
            w_advPend = w_riseBtn0;
          end else if (w_riseBtn0) begin
            w_cursor = w_cursorInc;
          end
        end
        ST_RUN: begin
          if (w_risePrgm) begin
            w_state = ST_PROGRAM;
            w_tick  = '0;
          end else if (w_risePp) begin
            w_state = ST_PAUSE;
          end else if (r_tick == TICK_LAST) begin
            w_tick = '0;
            if (w_halt) begin
              w_stable = 1'b1;
              w_state  = ST_PAUSE;
            end else begin
              w_step  = 1'b1;
              w_snap  = grid;
              w_gen   = w_genInc;
              w_first = 1'b0;
            end
          end else begin
            w_tick = r_tick + TW'(1);
          end
        end
        ST_PAUSE: begin
          if (w_risePrgm) begin
            w_state  = ST_PROGRAM;
            w_stable = 1'b0;
          end else if (w_risePp) begin
            w_state  = ST_RUN;
            w_stable = 1'b0;
          end else if (w_riseBtn0) begin
            w_step  = 1'b1;
            w_snap  = grid;
            w_gen   = w_genInc;
            w_first = 1'b0;
          end
        end
        default: w_state = ST_STOP;
      endcase
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_STOP;
      r_tick     <= '0;
      r_snap     <= '0;
      r_first    <= 1'b0;
      r_advPend  <= 1'b0;
      r_step     <= 1'b0;
      r_toggle   <= 1'b0;
      r_clear    <= 1'b0;
      r_cursor   <= 6'd0;
      r_gen      <= '0;
      r_stable   <= 1'b0;
      r_prevPrgm <= 1'b0;
      r_prevPp   <= 1'b0;
      r_prevBtn0 <= 1'b0;
      r_prevBtn1 <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_tick     <= w_tick;
      r_snap     <= w_snap;
      r_first    <= w_first;
      r_advPend  <= w_advPend;
      r_step     <= w_step;
      r_toggle   <= w_toggle;
      r_clear    <= w_clear;
      r_cursor   <= w_cursor;
      r_gen      <= w_gen;
      r_stable   <= w_stable;
      r_prevPrgm <= prgm;
      r_prevPp   <= pp;
      r_prevBtn0 <= btn0;
      r_prevBtn1 <= btn1;
    end
  end

  assign game_state = r_state;
  assign step       = r_step;
  assign toggle     = r_toggle;
  assign clear      = r_clear;
  assign cursor     = r_cursor;
  assign gen_count  = r_gen;
  assign stable     = r_stable;

endmodule

// File: tb/tb_gen_scheduler.sv
// Bench for gen_scheduler: directed scenarios then random buttons, every cycle
// compared against a behavioural model of the game rules.
module tb_gen_scheduler;

  localparam int TD    = 4;
  localparam int CELLS = 49;
  localparam int GW    = 16;
  localparam logic [48:0] BLINK_H = (49'b1 << 23) | (49'b1 << 24) | (49'b1 << 25);
  localparam logic [48:0] BLINK_V = (49'b1 << 17) | (49'b1 << 24) | (49'b1 << 31);
  localparam logic [48:0] BLOCK   = (49'b1 << 16) | (49'b1 << 17) | (49'b1 << 23) | (49'b1 << 24);

  logic clka = 1'b0;
  logic rst_n, stop, prgm, pp, btn0, btn1;
  logic [CELLS-1:0] grid;
  logic [1:0] game_state;
  logic step, toggle, clear, stable;
  logic [5:0] cursor;
  logic [GW-1:0] gen_count;

  int checks = 0;
  int failures = 0;
  bit flipOnStep = 1'b0;

  // Model of the game rules: mode number matches the game_state encoding.
  int mMode, mPhase, mCursor, mGen;
  logic [48:0] mSnap;
  bit mFresh, mAdvanceLater, mStep, mToggle, mClear, mStable;
  bit pPrgm, pPp, pB0, pB1;

  gen_scheduler #(.TICK_DIV(TD), .CELLS(CELLS), .GEN_W(GW)) dut (
    .clka(clka), .rst_n(rst_n), .stop(stop), .prgm(prgm), .pp(pp),
    .btn0(btn0), .btn1(btn1), .grid(grid), .game_state(game_state),
    .step(step), .toggle(toggle), .clear(clear), .cursor(cursor),
    .gen_count(gen_count), .stable(stable)
  );

  always #5 clka = ~clka;

  function automatic void modelReset();
    mMode = 0; mPhase = 0; mCursor = 0; mGen = 0; mSnap = '0;
    mFresh = 0; mAdvanceLater = 0; mStep = 0; mToggle = 0; mClear = 0; mStable = 0;
    pPrgm = 0; pPp = 0; pB0 = 0; pB1 = 0;
  endfunction

  function automatic void doStep();
    mStep = 1; mSnap = grid; mFresh = 0;
    if (mGen < (2 ** GW) - 1) mGen = mGen + 1;
  endfunction

  function automatic void modelEdge();
    bit rP, rPp, r0, r1;
    rP = prgm && !pPrgm; rPp = pp && !pPp; r0 = btn0 && !pB0; r1 = btn1 && !pB1;
    mStep = 0; mToggle = 0; mClear = 0;
    if (mAdvanceLater) begin
      mCursor = (mCursor + 1) % CELLS;
      mAdvanceLater = 0;
    end
    if (stop) begin
      if (mMode != 0) begin
        mClear = 1; mCursor = 0; mGen = 0; mPhase = 0; mStable = 0;
      end
      mMode = 0;
    end else if (mMode == 0) begin
      if (rP) mMode = 1;
      else if (rPp) begin mMode = 2; mPhase = 0; mFresh = 1; end
    end else if (mMode == 1) begin
      if (rPp) begin mMode = 2; mPhase = 0; mFresh = 1; end
      else if (r1) begin mToggle = 1; mAdvanceLater = r0; end
      else if (r0) mCursor = (mCursor + 1) % CELLS;
    end else if (mMode == 2) begin
      if (rP) begin mMode = 1; mPhase = 0; end
      else if (rPp) mMode = 3;
      else begin
        mPhase = (mPhase + 1) % TD;
        if (mPhase == 0) begin
          if (!mFresh && (grid == mSnap || grid == 0)) begin mStable = 1; mMode = 3; end
          else doStep();
        end
      end
    end else begin
      if (rP) begin mMode = 1; mStable = 0; end
      else if (rPp) begin mMode = 2; mStable = 0; end
      else if (r0) doStep();
    end
    pPrgm = prgm; pPp = pp; pB0 = btn0; pB1 = btn1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("game_state", 64'(game_state), 64'(mMode));
    chk("step", 64'(step), 64'(mStep));
    chk("toggle", 64'(toggle), 64'(mToggle));
    chk("clear", 64'(clear), 64'(mClear));
    chk("cursor", 64'(cursor), 64'(mCursor));
    chk("gen_count", 64'(gen_count), 64'(mGen));
    chk("stable", 64'(stable), 64'(mStable));
  endtask

  // Drives one cycle of inputs, then emulates the datapath flipping a blinker on each step.
  task automatic applyStimulus(input logic s, input logic p, input logic ppv,
                               input logic b0, input logic b1);
    stop = s; prgm = p; pp = ppv; btn0 = b0; btn1 = b1;
    @(posedge clka);
    modelEdge();
    #1;
    checkOutput();
    if (flipOnStep && step) begin
      if (grid == BLINK_H) grid = BLINK_V;
      else if (grid == BLINK_V) grid = BLINK_H;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g;
    logic [63:0] rnd;
    rst_n = 1'b0; stop = 0; prgm = 0; pp = 0; btn0 = 0; btn1 = 0; grid = BLINK_H;
    modelReset();
    #12;
    chk("rst_state", 64'(game_state), 64'd0);
    chk("rst_pulses", 64'({step, toggle, clear, stable}), 64'd0);
    chk("rst_counts", 64'({cursor, gen_count}), 64'd0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] run cadence from STOP");
    flipOnStep = 1'b1;
    applyStimulus(0, 0, 1, 0, 0);
    chk("run_entry", 64'(game_state), 64'd2);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(0, 0, 0, 0, 0);
      chk("step_cadence", 64'(step), 64'(k % 4 == 0));
    end
    chk("gen_after3", 64'(gen_count), 64'd3);
    for (int k = 0; k < 16; k++) applyStimulus(0, 0, 0, 0, 0);
    chk("gen_before_stop", 64'(gen_count), 64'd7);
    applyStimulus(1, 0, 0, 0, 0);
    chk("stop_state", 64'(game_state), 64'd0);
    chk("stop_clear", 64'(clear), 64'd1);
    chk("stop_gen", 64'(gen_count), 64'd0);
    chk("stop_cursor", 64'(cursor), 64'd0);
    applyStimulus(0, 0, 0, 0, 0);
    chk("clear_one_cycle", 64'(clear), 64'd0);

    $display("[TB] program mode cursor and toggle");
    flipOnStep = 1'b0;
    applyStimulus(0, 1, 1, 0, 0);
    chk("prgm_beats_pp", 64'(game_state), 64'd1);
    applyStimulus(0, 0, 0, 0, 0);
    for (int k = 0; k < 48; k++) begin
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end
    chk("cursor_last", 64'(cursor), 64'd48);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    chk("cursor_wrap", 64'(cursor), 64'd0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 1, 1);
    chk("both_toggle", 64'(toggle), 64'd1);
    chk("both_old_cursor", 64'(cursor), 64'd5);
    applyStimulus(0, 0, 0, 0, 0);
    chk("both_toggle_done", 64'(toggle), 64'd0);
    chk("both_new_cursor", 64'(cursor), 64'd6);

    $display("[TB] halt on static grid");
    grid = BLINK_H; flipOnStep = 1'b1;
    applyStimulus(0, 0, 1, 0, 0);
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 0, 0);
    for (int k = 0; k < 2 * TD && !step; k++) applyStimulus(0, 0, 0, 0, 0);
    grid = BLOCK; flipOnStep = 1'b0;
    for (int k = 0; k < 3 * TD && game_state != 2'b11; k++) applyStimulus(0, 0, 0, 0, 0);
    chk("halt_state", 64'(game_state), 64'd3);
    chk("halt_stable", 64'(stable), 64'd1);
    chk("halt_nostep", 64'(step), 64'd0);

    $display("[TB] pause single steps");
    g = mGen;
    applyStimulus(0, 0, 0, 1, 0);
    chk("single_step1", 64'(step), 64'd1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    chk("single_step2", 64'(step), 64'd1);
    applyStimulus(0, 0, 0, 0, 0);
    chk("single_gen", 64'(gen_count), 64'(g + 2));
    grid = BLINK_H; flipOnStep = 1'b1;
    applyStimulus(0, 0, 1, 0, 0);
    chk("resume_state", 64'(game_state), 64'd2);
    chk("resume_stable", 64'(stable), 64'd0);

    $display("[TB] async reset mid-step");
    for (int k = 0; k < 2 * TD + 1 && !step; k++) applyStimulus(0, 0, 0, 0, 0);
    chk("step_before_reset", 64'(step), 64'd1);
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    chk("areset_state", 64'(game_state), 64'd0);
    chk("areset_pulses", 64'({step, toggle, clear, stable}), 64'd0);
    chk("areset_counts", 64'({cursor, gen_count}), 64'd0);
    #1 rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] random stimulus");
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(9) == 0) begin
        case ($urandom_range(4))
          0: grid = '0;
          1: grid = BLINK_H;
          2: grid = BLINK_V;
          3: grid = BLOCK;
          default: begin rnd = {$urandom, $urandom}; grid = rnd[48:0]; end
        endcase
      end
      applyStimulus(logic'($urandom_range(39) == 0), logic'($urandom_range(9) == 0),
                    logic'($urandom_range(5) == 0), logic'($urandom_range(2) == 0),
                    logic'($urandom_range(3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
